// File: rtl/cart_map_pkg.sv
// Shared types, idle-bus constants and the map_active decoder for the
// cartridge mapper arbiter.
package cart_map_pkg;

  typedef enum logic [1:0] {SCAN, LOCKED, FAULT} state_t;

  // The default DSP/LoROM/HiROM channel sits at index NCH, one past the last coprocessor.
  localparam int DFLT_NCH = 6;

  localparam logic       IDLE_STROBE_N = 1'b1;
  localparam logic       IDLE_IRQ_N    = 1'b1;
  localparam logic [7:0] IDLE_CPU_DI   = 8'hFF;

  // Zero maps to the default index n, one-hot to its bit index; multi-hot returns 0.
  function automatic logic onehot_to_idx(input logic [31:0] v, input int n, output int idx);
    int hits;
    hits = 0;
    idx  = n;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        hits++;
        idx = i;
      end
    end
    if (hits > 1) idx = n;
    return (hits <= 1);
  endfunction

endpackage

// File: rtl/cart_map_qualifier.sv
// Qualifies map_active into a locked channel selection; tracks multi-hot
// conflicts and derives the turbo permission for the locked channel.
module cart_map_qualifier
  import cart_map_pkg::*;
#(
  parameter int               NCH              = DFLT_NCH,
  parameter int               LOCK_CYCLES      = 16,
  parameter logic [NCH-1:0]   TURBO_BLOCK_MASK = 6'b001010,
  parameter int               SW               = $clog2(NCH + 1)
) (
  input  logic           mclk,
  input  logic           rst,
  input  logic [NCH-1:0] map_active,
  output state_t         state,
  output logic [SW-1:0]  cand,
  output logic [SW-1:0]  sel,
  output logic           locked,
  output logic           conflict,
  output logic [7:0]     fault_cnt,
  output logic           turbo_allow
);

  localparam int CW = $clog2(LOCK_CYCLES) + 1;

  logic          dec_valid;
  int            dec_int;
  logic [SW-1:0] dec_idx;
  logic [CW-1:0] cnt;

  always_comb begin
    dec_int   = NCH;
    dec_valid = onehot_to_idx(32'(map_active), NCH, dec_int);
    dec_idx   = SW'(dec_int);
  end

  function automatic logic turbo_blocked(input logic [SW-1:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (idx == SW'(i)) b = TURBO_BLOCK_MASK[i];
    return b;
  endfunction

  // cand keeps tracking the decode during reset so a channel held through reset locks LOCK_CYCLES edges after release.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state       <= SCAN;
      cand        <= dec_idx;
      cnt         <= '0;
      sel         <= SW'(NCH);
      locked      <= 1'b0;
      conflict    <= 1'b0;
      fault_cnt   <= '0;
      turbo_allow <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (!dec_valid) begin
            state    <= FAULT;
            conflict <= 1'b1;
            if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
          end else if (dec_idx != cand) begin
            cand <= dec_idx;
            cnt  <= '0;
          end else if (cnt == CW'(LOCK_CYCLES - 1)) begin
            state       <= LOCKED;
            sel         <= cand;
            locked      <= 1'b1;
            turbo_allow <= ~turbo_blocked(cand);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LOCKED: begin
          if (!dec_valid || dec_idx != sel) begin
            locked      <= 1'b0;
            sel         <= SW'(NCH);
            turbo_allow <= 1'b0;
            cnt         <= '0;
            cand        <= dec_idx;
            if (!dec_valid) begin
              state    <= FAULT;
              conflict <= 1'b1;
              if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
            end else begin
              state <= SCAN;
            end
          end
        end
        FAULT: begin
          if (dec_valid) begin
            state <= SCAN;
            cand  <= dec_idx;
            cnt   <= '0;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: rtl/cart_map_arbiter.sv
// Routes one coprocessor mapper channel, or the default channel, onto the
// shared ROM/BSRAM/CPU/IRQ buses, idling all strobes until a selection locks.
module cart_map_arbiter
  import cart_map_pkg::*;
#(
  parameter int             NCH              = DFLT_NCH,
  parameter int             AW               = 24,
  parameter int             BW               = 20,
  parameter int             LOCK_CYCLES      = 16,
  parameter int             REG_OUT          = 1,
  parameter logic [NCH-1:0] TURBO_BLOCK_MASK = 6'b001010,
  localparam int            SW               = $clog2(NCH + 1)
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic [NCH-1:0]    map_active,
  input  logic [8*NCH-1:0]  ch_do,
  input  logic [NCH-1:0]    ch_irq_n,
  input  logic [AW*NCH-1:0] ch_rom_addr,
  input  logic [16*NCH-1:0] ch_rom_d,
  input  logic [NCH-1:0]    ch_rom_ce_n,
  input  logic [NCH-1:0]    ch_rom_oe_n,
  input  logic [NCH-1:0]    ch_rom_we_n,
  input  logic [NCH-1:0]    ch_rom_word,
  input  logic [BW*NCH-1:0] ch_bsram_addr,
  input  logic [8*NCH-1:0]  ch_bsram_d,
  input  logic [NCH-1:0]    ch_bsram_ce_n,
  input  logic [NCH-1:0]    ch_bsram_oe_n,
  input  logic [NCH-1:0]    ch_bsram_we_n,
  input  logic [7:0]        dflt_do,
  input  logic              dflt_irq_n,
  input  logic [AW-1:0]     dflt_rom_addr,
  input  logic [15:0]       dflt_rom_d,
  input  logic              dflt_rom_ce_n,
  input  logic              dflt_rom_oe_n,
  input  logic              dflt_rom_we_n,
  input  logic              dflt_rom_word,
  input  logic [BW-1:0]     dflt_bsram_addr,
  input  logic [7:0]        dflt_bsram_d,
  input  logic              dflt_bsram_ce_n,
  input  logic              dflt_bsram_oe_n,
  input  logic              dflt_bsram_we_n,
  output logic [7:0]        cpu_di,
  output logic              irq_n,
  output logic [AW-1:0]     rom_addr,
  output logic [15:0]       rom_d,
  output logic              rom_ce_n,
  output logic              rom_oe_n,
  output logic              rom_we_n,
  output logic              rom_word,
  output logic [BW-1:0]     bsram_addr,
  output logic [7:0]        bsram_d,
  output logic              bsram_ce_n,
  output logic              bsram_oe_n,
  output logic              bsram_we_n,
  output logic [SW-1:0]     sel,
  output logic              locked,
  output logic              conflict,
  output logic [7:0]        fault_cnt,
  output logic              turbo_allow
);

  state_t        state;
  logic [SW-1:0] cand;
  logic [SW-1:0] route_idx;
  logic          idle;

  logic [7:0]    cpu_di_p0, bsram_d_p0;
  logic [AW-1:0] rom_addr_p0;
  logic [15:0]   rom_d_p0;
  logic [BW-1:0] bsram_addr_p0;
  logic          irq_n_p0, rom_ce_n_p0, rom_oe_n_p0, rom_we_n_p0, rom_word_p0;
  logic          bsram_ce_n_p0, bsram_oe_n_p0, bsram_we_n_p0;

  cart_map_qualifier #(
    .NCH              (NCH),
    .LOCK_CYCLES      (LOCK_CYCLES),
    .TURBO_BLOCK_MASK (TURBO_BLOCK_MASK),
    .SW               (SW)
  ) u_qualifier (
    .mclk        (mclk),
    .rst         (rst),
    .map_active  (map_active),
    .state       (state),
    .cand        (cand),
    .sel         (sel),
    .locked      (locked),
    .conflict    (conflict),
    .fault_cnt   (fault_cnt),
    .turbo_allow (turbo_allow)
  );

  // p0: channel mux; FAULT routes the default channel, SCAN previews the candidate
  always_comb begin
    idle      = (state != LOCKED);
    route_idx = (state == LOCKED) ? sel : (state == FAULT) ? SW'(NCH) : cand;

    cpu_di_p0     = dflt_do;
    irq_n_p0      = dflt_irq_n;
    rom_addr_p0   = dflt_rom_addr;
    rom_d_p0      = dflt_rom_d;
    rom_ce_n_p0   = dflt_rom_ce_n;
    rom_oe_n_p0   = dflt_rom_oe_n;
    rom_we_n_p0   = dflt_rom_we_n;
    rom_word_p0   = dflt_rom_word;
    bsram_addr_p0 = dflt_bsram_addr;
    bsram_d_p0    = dflt_bsram_d;
    bsram_ce_n_p0 = dflt_bsram_ce_n;
    bsram_oe_n_p0 = dflt_bsram_oe_n;
    bsram_we_n_p0 = dflt_bsram_we_n;
    for (int i = 0; i < NCH; i++) begin
      if (route_idx == SW'(i)) begin
        cpu_di_p0     = ch_do[i*8 +: 8];
        irq_n_p0      = ch_irq_n[i];
        rom_addr_p0   = ch_rom_addr[i*AW +: AW];
        rom_d_p0      = ch_rom_d[i*16 +: 16];
        rom_ce_n_p0   = ch_rom_ce_n[i];
        rom_oe_n_p0   = ch_rom_oe_n[i];
        rom_we_n_p0   = ch_rom_we_n[i];
        rom_word_p0   = ch_rom_word[i];
        bsram_addr_p0 = ch_bsram_addr[i*BW +: BW];
        bsram_d_p0    = ch_bsram_d[i*8 +: 8];
        bsram_ce_n_p0 = ch_bsram_ce_n[i];
        bsram_oe_n_p0 = ch_bsram_oe_n[i];
        bsram_we_n_p0 = ch_bsram_we_n[i];
      end
    end

    if (idle) begin
      cpu_di_p0     = IDLE_CPU_DI;
      irq_n_p0      = IDLE_IRQ_N;
      rom_ce_n_p0   = IDLE_STROBE_N;
      rom_oe_n_p0   = IDLE_STROBE_N;
      rom_we_n_p0   = IDLE_STROBE_N;
      bsram_ce_n_p0 = IDLE_STROBE_N;
      bsram_oe_n_p0 = IDLE_STROBE_N;
      bsram_we_n_p0 = IDLE_STROBE_N;
    end
  end

  // p1: optional output register stage
  generate
    if (REG_OUT != 0) begin : g_reg_out
      always_ff @(posedge mclk) begin
        if (rst) begin
          cpu_di     <= IDLE_CPU_DI;
          irq_n      <= IDLE_IRQ_N;
          rom_addr   <= '0;
          rom_d      <= '0;
          rom_ce_n   <= IDLE_STROBE_N;
          rom_oe_n   <= IDLE_STROBE_N;
          rom_we_n   <= IDLE_STROBE_N;
          rom_word   <= 1'b0;
          bsram_addr <= '0;
          bsram_d    <= '0;
          bsram_ce_n <= IDLE_STROBE_N;
          bsram_oe_n <= IDLE_STROBE_N;
          bsram_we_n <= IDLE_STROBE_N;
        end else begin
          cpu_di     <= cpu_di_p0;
          irq_n      <= irq_n_p0;
          rom_addr   <= rom_addr_p0;
          rom_d      <= rom_d_p0;
          rom_ce_n   <= rom_ce_n_p0;
          rom_oe_n   <= rom_oe_n_p0;
          rom_we_n   <= rom_we_n_p0;
          rom_word   <= rom_word_p0;
          bsram_addr <= bsram_addr_p0;
          bsram_d    <= bsram_d_p0;
          bsram_ce_n <= bsram_ce_n_p0;
          bsram_oe_n <= bsram_oe_n_p0;
          bsram_we_n <= bsram_we_n_p0;
        end
      end
    end else begin : g_comb_out
      assign cpu_di     = cpu_di_p0;
      assign irq_n      = irq_n_p0;
      assign rom_addr   = rom_addr_p0;
      assign rom_d      = rom_d_p0;
      assign rom_ce_n   = rom_ce_n_p0;
      assign rom_oe_n   = rom_oe_n_p0;
      assign rom_we_n   = rom_we_n_p0;
      assign rom_word   = rom_word_p0;
      assign bsram_addr = bsram_addr_p0;
      assign bsram_d    = bsram_d_p0;
      assign bsram_ce_n = bsram_ce_n_p0;
      assign bsram_oe_n = bsram_oe_n_p0;
      assign bsram_we_n = bsram_we_n_p0;
    end
  endgenerate

endmodule

// File: tb/tb_cart_map_arbiter.sv
// Scoreboard bench for cart_map_arbiter with default parameters (NCH=6,
// LOCK_CYCLES=16, REG_OUT=1, turbo blocked on channels 1 and 3).
module tb_cart_map_arbiter;

  localparam int NCH = 6;
  localparam int AW  = 24;
  localparam int BW  = 20;
  localparam int SW  = 3;

  typedef struct packed {
    logic [7:0]  di;
    logic        irq;
    logic [23:0] ra;
    logic [15:0] rd;
    logic        ce, oe, we, wd;
    logic [19:0] ba;
    logic [7:0]  bd;
    logic        bce, boe, bwe;
  } bus_t;

  logic              mclk = 1'b0;
  logic              rst  = 1'b1;
  logic [NCH-1:0]    map_active = '0;
  logic [8*NCH-1:0]  ch_do;
  logic [NCH-1:0]    ch_irq_n;
  logic [AW*NCH-1:0] ch_rom_addr;
  logic [16*NCH-1:0] ch_rom_d;
  logic [NCH-1:0]    ch_rom_ce_n, ch_rom_oe_n, ch_rom_we_n, ch_rom_word;
  logic [BW*NCH-1:0] ch_bsram_addr;
  logic [8*NCH-1:0]  ch_bsram_d;
  logic [NCH-1:0]    ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n;
  logic [7:0]        dflt_do;
  logic              dflt_irq_n;
  logic [AW-1:0]     dflt_rom_addr;
  logic [15:0]       dflt_rom_d;
  logic              dflt_rom_ce_n, dflt_rom_oe_n, dflt_rom_we_n, dflt_rom_word;
  logic [BW-1:0]     dflt_bsram_addr;
  logic [7:0]        dflt_bsram_d;
  logic              dflt_bsram_ce_n, dflt_bsram_oe_n, dflt_bsram_we_n;

  logic [7:0]    cpu_di, bsram_d, fault_cnt;
  logic          irq_n, rom_ce_n, rom_oe_n, rom_we_n, rom_word;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_d;
  logic [BW-1:0] bsram_addr;
  logic          bsram_ce_n, bsram_oe_n, bsram_we_n;
  logic [SW-1:0] sel;
  logic          locked, conflict, turbo_allow;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   hold_wr  = 1'b0;
  bus_t sb[$];

  cart_map_arbiter dut (
    .mclk(mclk), .rst(rst), .map_active(map_active),
    .ch_do(ch_do), .ch_irq_n(ch_irq_n), .ch_rom_addr(ch_rom_addr), .ch_rom_d(ch_rom_d),
    .ch_rom_ce_n(ch_rom_ce_n), .ch_rom_oe_n(ch_rom_oe_n), .ch_rom_we_n(ch_rom_we_n),
    .ch_rom_word(ch_rom_word), .ch_bsram_addr(ch_bsram_addr), .ch_bsram_d(ch_bsram_d),
    .ch_bsram_ce_n(ch_bsram_ce_n), .ch_bsram_oe_n(ch_bsram_oe_n), .ch_bsram_we_n(ch_bsram_we_n),
    .dflt_do(dflt_do), .dflt_irq_n(dflt_irq_n), .dflt_rom_addr(dflt_rom_addr),
    .dflt_rom_d(dflt_rom_d), .dflt_rom_ce_n(dflt_rom_ce_n), .dflt_rom_oe_n(dflt_rom_oe_n),
    .dflt_rom_we_n(dflt_rom_we_n), .dflt_rom_word(dflt_rom_word),
    .dflt_bsram_addr(dflt_bsram_addr), .dflt_bsram_d(dflt_bsram_d),
    .dflt_bsram_ce_n(dflt_bsram_ce_n), .dflt_bsram_oe_n(dflt_bsram_oe_n),
    .dflt_bsram_we_n(dflt_bsram_we_n),
    .cpu_di(cpu_di), .irq_n(irq_n), .rom_addr(rom_addr), .rom_d(rom_d),
    .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n), .rom_we_n(rom_we_n), .rom_word(rom_word),
    .bsram_addr(bsram_addr), .bsram_d(bsram_d), .bsram_ce_n(bsram_ce_n),
    .bsram_oe_n(bsram_oe_n), .bsram_we_n(bsram_we_n),
    .sel(sel), .locked(locked), .conflict(conflict), .fault_cnt(fault_cnt),
    .turbo_allow(turbo_allow)
  );

  always #5 mclk = ~mclk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic tick;
    @(posedge mclk);
    #1;
  endtask

  task automatic randomize_inputs;
    for (int i = 0; i < NCH; i++) begin
      ch_do[i*8 +: 8]          = 8'($urandom);
      ch_rom_addr[i*AW +: AW]  = AW'($urandom);
      ch_rom_d[i*16 +: 16]     = 16'($urandom);
      ch_bsram_addr[i*BW +: BW] = BW'($urandom);
      ch_bsram_d[i*8 +: 8]     = 8'($urandom);
    end
    ch_irq_n      = NCH'($urandom);
    ch_rom_ce_n   = NCH'($urandom);
    ch_rom_oe_n   = NCH'($urandom);
    ch_rom_we_n   = NCH'($urandom);
    ch_rom_word   = NCH'($urandom);
    ch_bsram_ce_n = NCH'($urandom);
    ch_bsram_oe_n = NCH'($urandom);
    ch_bsram_we_n = NCH'($urandom);
    dflt_do         = 8'($urandom);
    dflt_irq_n      = 1'($urandom);
    dflt_rom_addr   = AW'($urandom);
    dflt_rom_d      = 16'($urandom);
    dflt_rom_ce_n   = 1'($urandom);
    dflt_rom_oe_n   = 1'($urandom);
    dflt_rom_we_n   = 1'($urandom);
    dflt_rom_word   = 1'($urandom);
    dflt_bsram_addr = BW'($urandom);
    dflt_bsram_d    = 8'($urandom);
    dflt_bsram_ce_n = 1'($urandom);
    dflt_bsram_oe_n = 1'($urandom);
    dflt_bsram_we_n = 1'($urandom);
    if (hold_wr) begin
      ch_rom_ce_n     = '0;
      ch_bsram_ce_n   = '0;
      ch_bsram_we_n   = '0;
      dflt_bsram_ce_n = 1'b0;
      dflt_bsram_we_n = 1'b0;
    end
  endtask

  // Expected bus for channel k (k==NCH is the default channel); idle forces strobes/irq/cpu_di.
  function automatic bus_t exp_bus(input int k, input bit idle);
    bus_t e;
    if (k == NCH)
      e = {dflt_do, dflt_irq_n, dflt_rom_addr, dflt_rom_d, dflt_rom_ce_n, dflt_rom_oe_n,
           dflt_rom_we_n, dflt_rom_word, dflt_bsram_addr, dflt_bsram_d, dflt_bsram_ce_n,
           dflt_bsram_oe_n, dflt_bsram_we_n};
    else
      e = {ch_do[k*8 +: 8], ch_irq_n[k], ch_rom_addr[k*AW +: AW], ch_rom_d[k*16 +: 16],
           ch_rom_ce_n[k], ch_rom_oe_n[k], ch_rom_we_n[k], ch_rom_word[k],
           ch_bsram_addr[k*BW +: BW], ch_bsram_d[k*8 +: 8], ch_bsram_ce_n[k],
           ch_bsram_oe_n[k], ch_bsram_we_n[k]};
    if (idle) begin
      e.di  = 8'hFF;
      e.irq = 1'b1;
      e.ce  = 1'b1; e.oe  = 1'b1; e.we  = 1'b1;
      e.bce = 1'b1; e.boe = 1'b1; e.bwe = 1'b1;
    end
    return e;
  endfunction

  // One mclk of fresh channel stimulus: expectation pushed at drive, popped after the registered edge.
  task automatic sb_cycle(input int k, input bit idle, input string tag);
    bus_t e, o;
    randomize_inputs();
    sb.push_back(exp_bus(k, idle));
    tick();
    e = sb.pop_front();
    o = {cpu_di, irq_n, rom_addr, rom_d, rom_ce_n, rom_oe_n, rom_we_n, rom_word,
         bsram_addr, bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n};
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL %s bus: got %h expected %h", tag, o, e);
    end
  endtask

  task automatic do_reset(input logic [NCH-1:0] map);
    rst = 1'b1;
    map_active = map;
    randomize_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    hold_wr = 1'b1;
    do_reset('0);
    n_checks++; if (sel !== 3'd6)       begin n_fail++; $display("FAIL reset_sel: got %0d expected 6", sel); end
    n_checks++; if (locked !== 1'b0)    begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
    n_checks++; if (conflict !== 1'b0)  begin n_fail++; $display("FAIL reset_conflict: got %b expected 0", conflict); end
    n_checks++; if (fault_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_fault_cnt: got %0d expected 0", fault_cnt); end
    n_checks++; if (turbo_allow !== 1'b0) begin n_fail++; $display("FAIL reset_turbo: got %b expected 0", turbo_allow); end
    n_checks++;
    if ({rom_ce_n, rom_oe_n, rom_we_n, bsram_ce_n, bsram_oe_n, bsram_we_n, irq_n} !== 7'h7F) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 1111111",
                         {rom_ce_n, rom_oe_n, rom_we_n, bsram_ce_n, bsram_oe_n, bsram_we_n, irq_n});
    end
    n_checks++; if (cpu_di !== 8'hFF) begin n_fail++; $display("FAIL reset_cpu_di: got %h expected ff", cpu_di); end
    n_checks++;
    if ({rom_addr, rom_d, rom_word, bsram_addr, bsram_d} !== '0) begin
      n_fail++; $display("FAIL reset_addr_data: got %h expected 0", {rom_addr, rom_d, rom_word, bsram_addr, bsram_d});
    end
    hold_wr = 1'b0;
  endtask

  task automatic test_lock_gsu;
    hold_wr = 1'b1;
    do_reset(6'b000100);
    for (int i = 1; i <= 16; i++) begin
      sb_cycle(2, 1'b1, "gsu_scan");
      if (i == 15) begin
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL gsu_early_lock: got %b expected 0 at cycle 15", locked); end
      end
    end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL gsu_lock16: got %b expected 1", locked); end
    n_checks++; if (sel !== 3'd2)    begin n_fail++; $display("FAIL gsu_sel: got %0d expected 2", sel); end
    n_checks++; if (rom_ce_n !== 1'b1) begin n_fail++; $display("FAIL gsu_ce_latency: got %b expected 1", rom_ce_n); end
    hold_wr = 1'b0;
    for (int i = 0; i < 8; i++) sb_cycle(2, 1'b0, "gsu_locked");
  endtask

  task automatic test_default_turbo;
    do_reset('0);
    for (int i = 0; i < 16; i++) sb_cycle(NCH, 1'b1, "dflt_scan");
    n_checks++; if (locked !== 1'b1)      begin n_fail++; $display("FAIL dflt_locked: got %b expected 1", locked); end
    n_checks++; if (sel !== 3'd6)         begin n_fail++; $display("FAIL dflt_sel: got %0d expected 6", sel); end
    n_checks++; if (turbo_allow !== 1'b1) begin n_fail++; $display("FAIL dflt_turbo: got %b expected 1", turbo_allow); end
    for (int i = 0; i < 4; i++) sb_cycle(NCH, 1'b0, "dflt_locked");
    map_active = 6'b001000;
    sb_cycle(NCH, 1'b0, "dflt_switch");
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL switch_unlock: got %b expected 0", locked); end
    for (int i = 0; i < 16; i++) sb_cycle(3, 1'b1, "sa1_scan");
    n_checks++; if (locked !== 1'b1)      begin n_fail++; $display("FAIL sa1_locked: got %b expected 1", locked); end
    n_checks++; if (sel !== 3'd3)         begin n_fail++; $display("FAIL sa1_sel: got %0d expected 3", sel); end
    n_checks++; if (turbo_allow !== 1'b0) begin n_fail++; $display("FAIL sa1_turbo: got %b expected 0", turbo_allow); end
  endtask

  task automatic test_conflict;
    hold_wr = 1'b1;
    do_reset(6'b000001);
    for (int i = 0; i < 16; i++) sb_cycle(0, 1'b1, "c0_scan");
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL c0_locked: got %b expected 1", locked); end
    sb_cycle(0, 1'b0, "c0_write");
    map_active = 6'b000011;
    sb_cycle(0, 1'b0, "c0_fault_edge");
    n_checks++; if (conflict !== 1'b1)  begin n_fail++; $display("FAIL conflict_set: got %b expected 1", conflict); end
    n_checks++; if (fault_cnt !== 8'd1) begin n_fail++; $display("FAIL fault_cnt_1: got %0d expected 1", fault_cnt); end
    sb_cycle(NCH, 1'b1, "fault_idle");
    n_checks++; if (bsram_we_n !== 1'b1) begin n_fail++; $display("FAIL fault_we_n: got %b expected 1", bsram_we_n); end
    map_active = 6'b000001;
    sb_cycle(NCH, 1'b1, "fault_exit");
    for (int i = 1; i <= 16; i++) begin
      sb_cycle(0, 1'b1, "relock_scan");
      if (i == 15) begin
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early: got %b expected 0", locked); end
      end
    end
    n_checks++; if (locked !== 1'b1)   begin n_fail++; $display("FAIL relock: got %b expected 1", locked); end
    n_checks++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_sticky: got %b expected 1", conflict); end
    hold_wr = 1'b0;
  endtask

  task automatic test_toggle;
    int route;
    do_reset(6'b000001);
    route = 0;
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 10; c++) begin
        map_active = (p % 2 == 0) ? 6'b000001 : 6'b000010;
        sb_cycle(route, 1'b1, "toggle_idle");
        route = (p % 2 == 0) ? 0 : 1;
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL toggle_locked: got %b expected 0 p=%0d c=%0d", locked, p, c); end
      end
    end
  endtask

  task automatic test_saturate;
    do_reset('0);
    for (int e = 1; e <= 300; e++) begin
      map_active = 6'b000011;
      tick();
      map_active = 6'b000000;
      tick();
      if (e == 10) begin
        n_checks++; if (fault_cnt !== 8'd10) begin n_fail++; $display("FAIL fault_cnt_10: got %0d expected 10", fault_cnt); end
      end
    end
    n_checks++; if (fault_cnt !== 8'd255) begin n_fail++; $display("FAIL fault_cnt_sat: got %0d expected 255", fault_cnt); end
    n_checks++; if (conflict !== 1'b1)    begin n_fail++; $display("FAIL sat_conflict: got %b expected 1", conflict); end
  endtask

  task automatic test_rst_mid;
    hold_wr = 1'b1;
    do_reset(6'b010000);
    for (int i = 0; i < 16; i++) sb_cycle(4, 1'b1, "c4_scan");
    sb_cycle(4, 1'b0, "c4_write");
    n_checks++; if (bsram_we_n !== 1'b0) begin n_fail++; $display("FAIL c4_we_active: got %b expected 0", bsram_we_n); end
    rst = 1'b1;
    tick();
    n_checks++; if (bsram_we_n !== 1'b1) begin n_fail++; $display("FAIL rst_we_n: got %b expected 1", bsram_we_n); end
    n_checks++; if (locked !== 1'b0)     begin n_fail++; $display("FAIL rst_locked: got %b expected 0", locked); end
    n_checks++; if (sel !== 3'd6)        begin n_fail++; $display("FAIL rst_sel: got %0d expected 6", sel); end
    rst = 1'b0;
    hold_wr = 1'b0;
  endtask

  initial begin
    randomize_inputs();
    test_reset();
    test_lock_gsu();
    test_default_turbo();
    test_conflict();
    test_toggle();
    test_saturate();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
